// File: rtl/systolic_skew_feeder_if.sv
// DMA beat handshake into the systolic skew feeder.
// A beat carries A column k in the low half and B row k in the next half.
interface systolic_skew_feeder_if;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Feeds an NxN systolic array: accepts one A column / B row per beat and skews lane i by i
// enable-cycles, then drains the pipeline with zeros so every partial product reaches the array.
module systolic_skew_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [15:0]           k_len,
    systolic_skew_feeder_if.slave dma,
    output logic                  clear_acc,
    output logic                  en,
    output logic [N*DATA_W-1:0]   a_left,
    output logic [N*DATA_W-1:0]   b_top,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           slice_count,
    output logic [31:0]           stall_cycles
);

    localparam int LANE_W    = N * DATA_W;
    localparam int DRAIN_CYC = 2 * (N - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_t;

    state_t      state_q;
    logic [15:0] k_len_q;
    logic [15:0] drain_cnt_q;
    logic [15:0] slice_count_q;
    logic [31:0] stall_cycles_q;
    logic        in_ready_q;
    logic        clear_acc_q;
    logic        busy_q;
    logic        done_q;

    logic              xfer_s;
    logic              en_s;
    logic [LANE_W-1:0] inj_a_s;
    logic [LANE_W-1:0] inj_b_s;
    logic              unused_in_s;

    // in_ready is a registered state decode, so it never depends on in_valid
    assign xfer_s      = in_ready_q && dma.in_valid;
    assign en_s        = xfer_s || (state_q == DRAIN);
    assign inj_a_s     = xfer_s ? dma.in_data[LANE_W-1:0]          : {LANE_W{1'b0}};
    assign inj_b_s     = xfer_s ? dma.in_data[2*LANE_W-1:LANE_W]   : {LANE_W{1'b0}};
    assign unused_in_s = ^dma.in_data;

    assign dma.in_ready  = in_ready_q;
    assign clear_acc     = clear_acc_q;
    assign en            = en_s;
    assign busy          = busy_q;
    assign done          = done_q;
    assign slice_count   = slice_count_q;
    assign stall_cycles  = stall_cycles_q;

    // Command sequencer and its registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            k_len_q        <= 16'd0;
            drain_cnt_q    <= 16'd0;
            slice_count_q  <= 16'd0;
            stall_cycles_q <= 32'd0;
            in_ready_q     <= 1'b0;
            clear_acc_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            clear_acc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        k_len_q        <= k_len;
                        slice_count_q  <= 16'd0;
                        stall_cycles_q <= 32'd0;
                        clear_acc_q    <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= CLEAR;
                    end
                end
                CLEAR: begin
                    drain_cnt_q <= 16'd0;
                    if (k_len_q != 16'd0) begin
                        in_ready_q <= 1'b1;
                        state_q    <= FEED;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                FEED: begin
                    if (dma.in_valid) begin
                        slice_count_q <= slice_count_q + 16'd1;
                        if (slice_count_q + 16'd1 == k_len_q) begin
                            in_ready_q <= 1'b0;
                            if (DRAIN_CYC == 0) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                state_q <= DRAIN;
                            end
                        end
                    end else if (stall_cycles_q != 32'hFFFF_FFFF) begin
                        stall_cycles_q <= stall_cycles_q + 32'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == 16'(DRAIN_CYC - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 16'd1;
                    end
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign a_left[0 +: DATA_W] = inj_a_s[0 +: DATA_W];
            assign b_top[0 +: DATA_W]  = inj_b_s[0 +: DATA_W];
        end else begin : g_chain
            logic [DATA_W-1:0] a_pipe_q [i];
            logic [DATA_W-1:0] b_pipe_q [i];

            // i-deep skew chain; frozen while en is low, flushed by CLEAR
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int j = 0; j < i; j++) begin
                        a_pipe_q[j] <= {DATA_W{1'b0}};
                        b_pipe_q[j] <= {DATA_W{1'b0}};
                    end
                end else if (state_q == CLEAR) begin
                    for (int j = 0; j < i; j++) begin
                        a_pipe_q[j] <= {DATA_W{1'b0}};
                        b_pipe_q[j] <= {DATA_W{1'b0}};
                    end
                end else if (en_s) begin
                    a_pipe_q[0] <= inj_a_s[i*DATA_W +: DATA_W];
                    b_pipe_q[0] <= inj_b_s[i*DATA_W +: DATA_W];
                    for (int j = 1; j < i; j++) begin
                        a_pipe_q[j] <= a_pipe_q[j-1];
                        b_pipe_q[j] <= b_pipe_q[j-1];
                    end
                end
            end

            assign a_left[i*DATA_W +: DATA_W] = a_pipe_q[i-1];
            assign b_top[i*DATA_W +: DATA_W]  = b_pipe_q[i-1];
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed + randomized bench for systolic_skew_feeder against a beat-level reference model
// where lane i at en-cycle e carries beat e-i (zero outside the accepted beats).
module tb_systolic_skew_feeder;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int LW = N * DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   k_len = 16'd0;
    logic          clear_acc, en, busy, done;
    logic [LW-1:0] a_left, b_top;
    logic [15:0]   slice_count;
    logic [31:0]   stall_cycles;

    systolic_skew_feeder_if dma ();

    systolic_skew_feeder #(.N(N), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len), .dma(dma),
        .clear_acc(clear_acc), .en(en), .a_left(a_left), .b_top(b_top),
        .busy(busy), .done(done), .slice_count(slice_count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model
    bit               m_active, m_clear, m_done;
    int               m_k, m_beats, m_drain_left, m_e;
    logic [31:0]      m_stall;
    logic [2*LW-1:0]  beats[$];
    logic [2*LW-1:0]  src[$];
    int               obs_en_count;
    bit               seen_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_val(input int t, input int lane, input bit is_b);
        logic [2*LW-1:0] b;
        if (t < 0 || t >= beats.size()) return {DW{1'b0}};
        b = beats[t];
        return b[(is_b ? LW : 0) + lane*DW +: DW];
    endfunction

    task automatic model_reset();
        m_active = 0; m_clear = 0; m_done = 0;
        m_k = 0; m_beats = 0; m_drain_left = 0; m_e = 0; m_stall = 32'd0;
        beats.delete();
    endtask

    // one clock: drive at negedge, check 1 ns later, advance model, return at next negedge
    task automatic cycle(input logic st, input logic [15:0] kl, input logic vld, input logic [2*LW-1:0] data);
        logic [LW-1:0] ea, eb;
        logic exp_rdy, exp_x, exp_en;
        start = st; k_len = kl; dma.in_valid = vld;
        dma.in_data = {{(256-2*LW){1'b1}}, data};
        #1;
        exp_rdy = m_active && !m_clear && (m_beats < m_k);
        exp_x   = exp_rdy && vld;
        exp_en  = exp_x || (m_active && !m_clear && m_beats == m_k && m_drain_left > 0);
        for (int i = 0; i < N; i++) begin
            ea[i*DW +: DW] = (i == 0) ? (exp_x ? data[0 +: DW] : {DW{1'b0}}) : lane_val(m_e - i, i, 1'b0);
            eb[i*DW +: DW] = (i == 0) ? (exp_x ? data[LW +: DW] : {DW{1'b0}}) : lane_val(m_e - i, i, 1'b1);
        end
        check("clear_acc", clear_acc, m_clear);
        check("in_ready", dma.in_ready, exp_rdy);
        check("en", en, exp_en);
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("a_left", a_left, ea);
        check("b_top", b_top, eb);
        check("slice_count", slice_count, 64'(m_beats));
        check("stall_cycles", stall_cycles, m_stall);
        if (en === 1'b1) obs_en_count++;
        if (done === 1'b1) seen_done = 1;
        m_done = 0;
        if (!m_active) begin
            if (st) begin
                m_active = 1; m_clear = 1; m_k = int'(kl); m_beats = 0; m_stall = 32'd0;
                m_drain_left = 2*(N-1); m_e = 0; beats.delete();
            end
        end else if (m_clear) begin
            m_clear = 0;
            if (m_k == 0) begin m_active = 0; m_done = 1; end
        end else if (m_beats < m_k) begin
            if (vld) begin beats.push_back(data); m_beats++; m_e++; end
            else if (m_stall != 32'hFFFF_FFFF) m_stall++;
        end else begin
            m_drain_left--; m_e++;
            if (m_drain_left == 0) begin m_active = 0; m_done = 1; end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_random(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    // run one command; optional forced stall after a given beat count and a stray restart
    task automatic run_cmd(input logic [15:0] kl, input int stall_pct, input int stall_after,
                           input int stall_len, input logic [15:0] restart_kl);
        int   stalls;
        bit   restarted;
        logic vld, st;
        logic [2*LW-1:0] d;
        stalls = 0; restarted = 0; obs_en_count = 0; seen_done = 0;
        cycle(1'b1, kl, 1'b0, {2*LW{1'b0}});
        for (int c = 0; c < 400; c++) begin
            st = 1'b0;
            if (m_active && !m_clear && m_beats < m_k) begin
                if (m_beats == stall_after && stalls < stall_len) begin
                    vld = 1'b0; stalls++;
                end else begin
                    vld = ($urandom_range(99) >= stall_pct);
                end
                if (restart_kl != 16'd0 && !restarted && m_beats == 1) begin
                    st = 1'b1; restarted = 1;
                end
            end else begin
                vld = 1'($urandom_range(1));
            end
            d = (m_beats < src.size()) ? src[m_beats] : {$urandom, $urandom, $urandom, $urandom};
            cycle(st, st ? restart_kl : kl, vld, d);
            if (seen_done) break;
        end
        check("cmd_done", seen_done, 1'b1);
        check("en_total", 64'(obs_en_count), (kl == 16'd0) ? 64'd0 : 64'(kl) + 64'(2*(N-1)));
        check("final_slices", slice_count, kl);
    endtask

    initial begin
        logic [2*LW-1:0] d;
        model_reset();
        dma.in_valid = 1'b0;
        dma.in_data  = 256'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_en", en, 1'b0);
        check("rst_a_left", a_left, {LW{1'b0}});
        check("rst_stall", stall_cycles, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // k_len=1 with A={1,2,3,4}, B={5,6,7,8}, start on first edge after reset
        for (int i = 0; i < N; i++) begin
            d[i*DW +: DW]      = DW'(i + 1);
            d[LW + i*DW +: DW] = DW'(i + 5);
        end
        src.delete(); src.push_back(d);
        run_cmd(16'd1, 0, -1, 0, 16'd0);

        // k_len=4, three stall cycles after two beats
        fill_random(4);
        run_cmd(16'd4, 0, 2, 3, 16'd0);
        check("stall3", stall_cycles, 32'd3);

        // k_len=0
        run_cmd(16'd0, 0, -1, 0, 16'd0);

        // stray start during FEED is ignored
        fill_random(5);
        run_cmd(16'd5, 0, -1, 0, 16'd9);

        // signed extremes
        for (int i = 0; i < N; i++) begin
            d[i*DW +: DW]      = 16'h8000;
            d[LW + i*DW +: DW] = 16'h7FFF;
        end
        src.delete(); src.push_back(d);
        run_cmd(16'd1, 0, -1, 0, 16'd0);

        // reset during DRAIN
        fill_random(2);
        seen_done = 0;
        cycle(1'b1, 16'd2, 1'b0, {2*LW{1'b0}});
        for (int c = 0; c < 20 && !(m_active && !m_clear && m_beats == m_k && m_drain_left < 2*(N-1)); c++)
            cycle(1'b0, 16'd2, 1'b1, (m_beats < src.size()) ? src[m_beats] : {2*LW{1'b0}});
        check("in_drain", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rstd_busy", busy, 1'b0);
        check("rstd_en", en, 1'b0);
        check("rstd_a_left", a_left, {LW{1'b0}});
        check("rstd_b_top", b_top, {LW{1'b0}});
        check("rstd_slices", slice_count, 16'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b0, 16'd0, 1'b0, {2*LW{1'b0}});
        fill_random(2);
        run_cmd(16'd2, 0, -1, 0, 16'd0);

        // randomized commands with random stalls
        for (int r = 0; r < 6; r++) begin
            logic [15:0] kr;
            kr = 16'($urandom_range(1, 7));
            fill_random(int'(kr));
            run_cmd(kr, 30, -1, 0, 16'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
